spi_master: RTL and testbench

Single-channel SPI master for the `spi` block, moving one 8-bit word per transfer, full duplex. It bridges an internal valid/ready byte interface to external SCLK/MOSI/MISO/CS pins, with per-transfer selectable CPOL/CPHA mode and a programmable SCLK divider. All logic runs in one system clock domain.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clk_div.sv | 36 +++
 rtl/spi_master.sv | 183 ++++++++++++++++++
 tb/tb_spi_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the single-channel SPI master.
// Latency: none, because this file holds declarations only.
// Backpressure: not applicable.
package spi_pkg;

   localparam int DATA_W = 8;
   localparam int EDGE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      LEAD,
      XFER,
      TRAIL
   } spi_state_t;

   // Mirror a word end for end, so the LSB-first build can reuse the MSB-first shifters.
   function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = v[DATA_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period tick generator: one-cycle pulse every value_divide clk cycles while enabled.
// Latency: the first tick comes value_divide cycles after en rises.
// Backpressure: none; the counter restarts whenever en is low.
module spi_clk_div #(
   parameter int value_divide = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (value_divide > 2) ? $clog2(value_divide) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(value_divide - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Tick at terminal count, then wrap; hold at zero while disabled.
   always_comb begin
      tick  = en && (cnt_q == TERM);
      cnt_d = cnt_q + 1'b1;
      if (!en || tick) begin
         cnt_d = '0;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Full-duplex 8-bit SPI master, CPOL/CPHA and CS level latched per transfer; SPI_LSB_FIRST_EN selects LSB-first order.
// Latency: 18*value_divide clk cycles from accept until ready returns, with data_receive updated in that same cycle.
// Backpressure: ready is low for the whole transfer; valid outside IDLE is ignored, never queued.
module spi_master
   import spi_pkg::*;
#(
   parameter int value_divide = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CPOL,
   input  logic              CPHA,
   input  logic              CS_input,
   input  logic              valid,
   input  logic [DATA_W-1:0] data_send,
   output logic              ready,
   output logic [DATA_W-1:0] data_receive,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              CS_output
);

   localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(15);
   localparam logic [EDGE_W-1:0] EDGE_FINAL = EDGE_W'(14);

   spi_state_t        state_q, state_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              csi_q, csi_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rxd_q, rxd_d;
   logic [EDGE_W-1:0] edge_q, edge_d;
   logic              mosi_q, mosi_d;
   logic              sclk_q, sclk_d;
   logic              cs_q, cs_d;

   logic              tick;
   logic              xfer_edge;
   logic              lead_evt;
   logic              trail_evt;
   logic              sample_evt;
   logic              shift_evt;
   logic [DATA_W-1:0] load_word;
   logic [DATA_W-1:0] rx_word;

`ifdef SPI_LSB_FIRST_EN
   assign load_word = bit_reverse(data_send);
   assign rx_word   = bit_reverse(rx_q);
`else
   assign load_word = data_send;
   assign rx_word   = rx_q;
`endif

   spi_clk_div #(
      .value_divide(value_divide)
   ) u_clk_div (
      .clk (clk),
      .rst (rst),
      .en  (state_q != IDLE),
      .tick(tick)
   );

   // Classify each tick: the LEAD->XFER tick is leading edge 0, then XFER ticks 0..14 give edges 1..15,
   // and XFER tick 15 only moves to TRAIL. Odd edges are trailing; the last trailing edge never shifts.
   always_comb begin
      xfer_edge  = tick && (state_q == XFER) && (edge_q != EDGE_LAST);
      lead_evt   = (tick && (state_q == LEAD)) || (xfer_edge && edge_q[0]);
      trail_evt  = xfer_edge && !edge_q[0];
      sample_evt = cpha_q ? trail_evt : lead_evt;
      shift_evt  = cpha_q ? lead_evt : (trail_evt && (edge_q != EDGE_FINAL));
   end

   // Next-state, shifters and pin levels.
   always_comb begin
      state_d = state_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      csi_d   = csi_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rxd_d   = rxd_q;
      edge_d  = edge_q;
      mosi_d  = mosi_q;
      sclk_d  = sclk_q;
      cs_d    = cs_q;

      case (state_q)
         IDLE: begin
            sclk_d = CPOL;
            cs_d   = CS_input;
            mosi_d = 1'b0;
            edge_d = '0;
            if (valid) begin
               state_d = LEAD;
               cpol_d  = CPOL;
               cpha_d  = CPHA;
               csi_d   = CS_input;
               cs_d    = ~CS_input;
               rx_d    = '0;
               // CPHA=0 puts the first bit out now; CPHA=1 waits for the first leading edge.
               tx_d    = CPHA ? load_word : {load_word[DATA_W-2:0], 1'b0};
               mosi_d  = CPHA ? 1'b0 : load_word[DATA_W-1];
            end
         end
         LEAD: begin
            if (tick) begin
               state_d = XFER;
            end
         end
         XFER: begin
            if (tick) begin
               if (edge_q == EDGE_LAST) begin
                  state_d = TRAIL;
                  edge_d  = '0;
               end else begin
                  edge_d = edge_q + 1'b1;
               end
            end
         end
         TRAIL: begin
            if (tick) begin
               state_d = IDLE;
               sclk_d  = cpol_q;
               cs_d    = csi_q;
               mosi_d  = 1'b0;
               rxd_d   = rx_word;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (lead_evt || trail_evt) begin
         sclk_d = ~sclk_q;
      end
      if (shift_evt) begin
         mosi_d = tx_q[DATA_W-1];
         tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end
      if (sample_evt) begin
         rx_d = {rx_q[DATA_W-2:0], spi_miso};
      end
   end

   // State and output registers; reset drops straight back to idle bus levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         csi_q   <= 1'b1;
         tx_q    <= '0;
         rx_q    <= '0;
         rxd_q   <= '0;
         edge_q  <= '0;
         mosi_q  <= 1'b0;
         sclk_q  <= CPOL;
         cs_q    <= CS_input;
      end else begin
         state_q <= state_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         csi_q   <= csi_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rxd_q   <= rxd_d;
         edge_q  <= edge_d;
         mosi_q  <= mosi_d;
         sclk_q  <= sclk_d;
         cs_q    <= cs_d;
      end
   end

   assign ready        = (state_q == IDLE);
   assign data_receive = rxd_q;
   assign spi_clk      = sclk_q;
   assign spi_mosi     = mosi_q;
   assign CS_output    = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed and randomized transfers against a bench-side SPI slave/monitor and expected-word model.
// Latency: each transfer is expected to keep ready low for 18*N cycles.
// Backpressure: requests are only issued while ready is high, apart from a deliberate mid-transfer poke.
module tb_spi_master;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       CPOL;
   logic       CPHA;
   logic       CS_input;
   logic       valid;
   logic [7:0] data_send;
   logic       ready;
   logic [7:0] data_receive;
   logic       spi_clk;
   logic       spi_mosi;
   logic       spi_miso;
   logic       CS_output;

   logic       lb_sel;
   logic       slave_bit;
   logic [7:0] exp_rx;

   int n_tests = 0;
   int n_fail  = 0;

   assign spi_miso = lb_sel ? spi_mosi : slave_bit;

   always #10 clk = ~clk;

   spi_master #(
      .value_divide(N)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .CPOL        (CPOL),
      .CPHA        (CPHA),
      .CS_input    (CS_input),
      .valid       (valid),
      .data_send   (data_send),
      .ready       (ready),
      .data_receive(data_receive),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .CS_output   (CS_output)
   );

   // k-th bit on the wire for word b, in the configured bit order.
   function automatic logic order_bit(input logic [7:0] b, input int k);
      logic [7:0] t;
      t = b;
      if (k < 0 || k > 7) return 1'b0;
`ifdef SPI_LSB_FIRST_EN
      return t[k];
`else
      return t[7-k];
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // One transfer; returns on the first negedge with ready high again.
   task automatic do_xfer(input logic [7:0] tx, input logic [7:0] slv, input logic lb,
                          input logic cp, input logic ch, input logic csi,
                          input logic b2b, input logic poke, input string tag);
      logic [7:0] mon;
      logic [7:0] exp_mon;
      logic [7:0] new_rx;
      logic       prev;
      logic       is_lead;
      int         lowcnt;
      int         cslow;
      int         nlead;
      int         ntrail;
      int         badint;
      int         first_edge;
      int         last_edge;
      int         held_bad;
      int         sl_idx;

      mon = '0; lowcnt = 0; cslow = 0; nlead = 0; ntrail = 0; badint = 0;
      first_edge = -1; last_edge = 0; held_bad = 0; sl_idx = 0;

      if (!b2b) @(negedge clk);
      CPOL = cp; CPHA = ch; CS_input = csi; lb_sel = lb;
      if (!b2b) repeat (2) @(negedge clk);
      slave_bit = ch ? 1'b0 : order_bit(slv, 0);

      check({tag, "_idle_ready"}, 32'(ready), 32'(1'b1));
      check({tag, "_idle_sclk"}, 32'(spi_clk), 32'(cp));
      check({tag, "_idle_cs"}, 32'(CS_output), 32'(csi));

      valid = 1'b1; data_send = tx;
      @(negedge clk);
      valid = 1'b0; data_send = 8'($urandom);
      prev = cp;

      while (ready !== 1'b1 && lowcnt < 2000) begin
         lowcnt++;
         if (CS_output === ~csi) cslow++;
         if (data_receive !== exp_rx) held_bad++;
         if (poke && lowcnt == 30) begin
            valid = 1'b1; data_send = 8'h12;
         end else begin
            valid = 1'b0;
         end
         if (spi_clk !== prev) begin
            is_lead = (prev === cp);
            if (first_edge < 0) first_edge = lowcnt;
            else if (lowcnt - last_edge != N) badint++;
            last_edge = lowcnt;
            if (is_lead) nlead++; else ntrail++;
            if (ch ? !is_lead : is_lead) mon = {mon[6:0], spi_mosi};
            if (ch ? is_lead : !is_lead) begin
               if (ch) begin
                  slave_bit = order_bit(slv, sl_idx);
                  sl_idx++;
               end else begin
                  sl_idx++;
                  slave_bit = order_bit(slv, sl_idx);
               end
            end
            prev = spi_clk;
         end
         @(negedge clk);
      end

      for (int k = 0; k < 8; k++) exp_mon[7-k] = order_bit(tx, k);
      new_rx = lb ? tx : slv;

      check({tag, "_ready_low_cycles"}, 32'(lowcnt), 32'(18 * N));
      check({tag, "_cs_low_cycles"}, 32'(cslow), 32'(18 * N));
      check({tag, "_lead_edges"}, 32'(nlead), 32'd8);
      check({tag, "_trail_edges"}, 32'(ntrail), 32'd8);
      check({tag, "_first_edge"}, 32'(first_edge), 32'(N + 1));
      check({tag, "_half_period_bad"}, 32'(badint), 32'd0);
      check({tag, "_mosi_bits"}, 32'(mon), 32'(exp_mon));
      check({tag, "_rx_held"}, 32'(held_bad), 32'd0);
      check({tag, "_rx_word"}, 32'(data_receive), 32'(new_rx));
      check({tag, "_end_sclk"}, 32'(spi_clk), 32'(cp));
      check({tag, "_end_cs"}, 32'(CS_output), 32'(csi));
      check({tag, "_end_mosi"}, 32'(spi_mosi), 32'd0);
      exp_rx = new_rx;
   endtask

   initial begin
      int         bad;
      logic [7:0] rtx;
      logic [7:0] rslv;
      logic [2:0] rcfg;
      logic [1:0] mode;

      rst = 1'b1; CPOL = 1'b1; CPHA = 1'b0; CS_input = 1'b1; valid = 1'b0;
      data_send = 8'h00; lb_sel = 1'b1; slave_bit = 1'b0; exp_rx = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_cs", 32'(CS_output), 32'd1);
      check("rst_sclk", 32'(spi_clk), 32'd1);
      check("rst_rx", 32'(data_receive), 32'h00);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      CPOL = 1'b0;
      @(negedge clk);
      check("idle_track_cpol", 32'(spi_clk), 32'd0);
      CPOL = 1'b1;

      do_xfer(8'hAF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "af");
      repeat (40) @(negedge clk);
      do_xfer(8'h55, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "x55");

      for (int m = 0; m < 4; m++) begin
         mode = 2'(m);
         do_xfer(8'hA5, 8'h00, 1'b1, mode[1], mode[0], 1'b1, 1'b0, 1'b0, $sformatf("a5_m%0d", m));
      end

      do_xfer(8'h3E, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "poke");
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (ready !== 1'b1 || CS_output !== 1'b1 || data_receive !== exp_rx) bad++;
      end
      check("poke_no_second_xfer", 32'(bad), 32'd0);

      do_xfer(8'h81, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "b2b_a");
      do_xfer(8'h7E, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "b2b_b");

      for (int i = 0; i < 10; i++) begin
         rtx  = 8'($urandom);
         rslv = 8'($urandom);
         rcfg = 3'($urandom_range(0, 7));
         do_xfer(rtx, rslv, 1'b0, rcfg[2], rcfg[1], rcfg[0], 1'b0, 1'b0, $sformatf("rnd%0d", i));
      end

      @(negedge clk);
      CPOL = 1'b0; CPHA = 1'b1; CS_input = 1'b1; lb_sel = 1'b1;
      repeat (2) @(negedge clk);
      valid = 1'b1; data_send = 8'hC3;
      @(negedge clk);
      valid = 1'b0;
      repeat (35) @(negedge clk);
      check("abort_busy", 32'(ready), 32'd0);
      check("abort_cs_active", 32'(CS_output), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_cs", 32'(CS_output), 32'd1);
      check("abort_sclk", 32'(spi_clk), 32'd0);
      check("abort_rx", 32'(data_receive), 32'h00);
      exp_rx = 8'h00;
      do_xfer(8'h3C, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "after_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
